// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the 16:1 mux arbiter.
// "release" is a reserved word, so the holder's give-up strobe is release_grant.
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic        release_grant;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        preempt;

    modport master (
        output req, release_grant,
        input  sel, gnt, busy, preempt
    );

    modport slave (
        input  req, release_grant,
        output sel, gnt, busy, preempt
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the 16:1 mux select, with a per-grant hold limit.
// All outputs are registered; an IDLE bubble always separates two grants.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux16_rr_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        preempt_q, preempt_d;

    logic [3:0]  win;
    logic        found;

    // First requester at or after ptr, wrapping modulo 16.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && bus.req[ptr_q + i[3:0]]) begin
                win   = ptr_q + i[3:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    sel_d   = win;
                    gnt_d   = 16'b1 << win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release wins over expiry, so a simultaneous release is not a preemption.
                if (bus.release_grant || !bus.req[sel_q] || cnt_q == HOLD_LAST) begin
                    preempt_d = bus.release_grant ? 1'b0 : bus.req[sel_q];
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 4'd1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: a vector table plus hand-written corner sequences.
// Two instances (hold limits 8 and 4) receive identical stimulus.
module tb_mux16_rr_arbiter;
    logic clk = 1'b0;
    logic rst;

    mux16_rr_arbiter_if bus8 ();
    mux16_rr_arbiter_if bus4 ();

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    mux16_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rel;
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        busy;
        logic        preempt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [15:0] q, input logic l,
                       input logic [3:0] s, input logic [15:0] g, input logic b, input logic p);
        vec_t v;
        v.rst = r; v.req = q; v.rel = l; v.sel = s; v.gnt = g; v.busy = b; v.preempt = p;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [15:0] q, input logic l);
        @(negedge clk);
        rst = r;
        bus8.req = q; bus8.release_grant = l;
        bus4.req = q; bus4.release_grant = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit use4, input logic [3:0] s,
                         input logic [15:0] g, input logic b, input logic p);
        logic [3:0]  as;
        logic [15:0] ag;
        logic        ab, ap;
        as = use4 ? bus4.sel : bus8.sel;
        ag = use4 ? bus4.gnt : bus8.gnt;
        ab = use4 ? bus4.busy : bus8.busy;
        ap = use4 ? bus4.preempt : bus8.preempt;
        checks++;
        if ({as, ag, ab, ap} !== {s, g, b, p}) begin
            errors++;
            $display("FAIL %s: got sel=%0d gnt=%h busy=%b preempt=%b, want sel=%0d gnt=%h busy=%b preempt=%b",
                     name, as, ag, ab, ap, s, g, b, p);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.req = '0; bus8.release_grant = 1'b0;
        bus4.req = '0; bus4.release_grant = 1'b0;

        // Hold-limit expiry with a single requester, MAX_HOLD=8.
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 16'h0001, 0, 0, 16'h0001, 1, 0);
        add(0, 16'h0001, 0, 0, 16'h0000, 0, 1);
        add(0, 16'h0001, 0, 0, 16'h0001, 1, 0);
        // All requesting with release held: 1-cycle grants, 1-cycle bubbles, sel 0..15,0,1.
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < 18; k++) begin
            add(0, 16'hFFFF, 1, 4'(k % 16), 16'h0001 << (k % 16), 1, 0);
            add(0, 16'hFFFF, 1, 4'(k % 16), 16'h0000, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].rel);
            check($sformatf("vec%0d", i), 1'b0, vecs[i].sel, vecs[i].gnt, vecs[i].busy, vecs[i].preempt);
        end

        // Pointer wrap 15 -> 0.
        step(1, 16'h0000, 0);
        step(0, 16'h4000, 0); check("wrap_g14", 0, 14, 16'h4000, 1, 0);
        step(0, 16'h4000, 1); check("wrap_rel14", 0, 14, 16'h0000, 0, 0);
        step(0, 16'h0009, 0); check("wrap_g0", 0, 0, 16'h0001, 1, 0);
        step(0, 16'h0009, 1); check("wrap_rel0", 0, 0, 16'h0000, 0, 0);
        step(0, 16'h0009, 0); check("wrap_g3", 0, 3, 16'h0008, 1, 0);

        // Request drop in the third grant cycle, then ptr must be 6.
        step(1, 16'h0000, 0);
        step(0, 16'h0020, 0); check("drop_g5", 0, 5, 16'h0020, 1, 0);
        step(0, 16'h0020, 0);
        step(0, 16'h0020, 0); check("drop_hold", 0, 5, 16'h0020, 1, 0);
        step(0, 16'h0000, 0); check("drop_end", 0, 5, 16'h0000, 0, 0);
        step(0, 16'hFFFF, 0); check("drop_ptr6", 0, 6, 16'h0040, 1, 0);

        // MAX_HOLD=4: plain expiry, then release coinciding with expiry.
        step(1, 16'h0000, 0);
        step(0, 16'h0001, 0); check("h4_g0", 1, 0, 16'h0001, 1, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0001, 0); check("h4_hold4", 1, 0, 16'h0001, 1, 0);
        step(0, 16'h0001, 0); check("h4_expire", 1, 0, 16'h0000, 0, 1);
        step(0, 16'h0001, 0); check("h4_regrant", 1, 0, 16'h0001, 1, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0001, 0);
        step(0, 16'h0001, 1); check("h4_rel_at_expiry", 1, 0, 16'h0000, 0, 0);

        // Reset mid-grant clears everything including ptr.
        step(1, 16'h0000, 0);
        step(0, 16'h0200, 0); check("rst_g9", 0, 9, 16'h0200, 1, 0);
        step(0, 16'h0200, 0);
        step(1, 16'h0200, 0); check("rst_mid", 0, 0, 16'h0000, 0, 0);
        step(0, 16'hFFFF, 0); check("rst_ptr0", 0, 0, 16'h0001, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
